// File: rtl/ripple_count_sampler.sv
// rtl/ripple_count_sampler.sv - brings an asynchronous 4-bit ripple count into the clk domain
// Synchroniser, stability filter, delta accumulator with flags, and snapshot handshake.
module ripple_count_sampler #(
    parameter int CNT_W      = 16,
    parameter int STABLE_CYC = 2,
    parameter int MATCH_VAL  = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       q_in,
    input  logic             clear,
    input  logic             snap_req,
    input  logic             snap_ready,
    output logic             snap_valid,
    output logic [CNT_W-1:0] snap_count,
    output logic [CNT_W-1:0] count,
    output logic             stable,
    output logic             wrap_pulse,
    output logic             cmp_hit,
    output logic             overflow
);

    localparam int               RUN_W   = $clog2(STABLE_CYC + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYC);
    localparam logic [CNT_W-1:0] MATCH   = CNT_W'(MATCH_VAL);

    typedef enum logic {IDLE, HOLD} snap_state_e;

    logic [3:0]       s1_q, s1_d, s2_q, s2_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [3:0]       base_q, base_d;
    logic             primed_q, primed_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             wrap_q, wrap_d;
    logic             cmp_q, cmp_d;
    logic [CNT_W-1:0] snap_count_q, snap_count_d;
    snap_state_e      state_q, state_d;

    logic             accept;
    logic [3:0]       delta;
    logic [CNT_W:0]   sum;

    // run_d compares the value s2 is about to take (s1) with its current value,
    // so the accept edge lands exactly STABLE_CYC cycles after s2 settles.
    always_comb begin
        s1_d = q_in;
        s2_d = s1_q;
        if (s1_q != s2_q) begin
            run_d = '0;
        end else if (run_q == RUN_MAX) begin
            run_d = run_q;
        end else begin
            run_d = run_q + RUN_W'(1);
        end
        accept = (run_d == RUN_MAX) && (run_q != RUN_MAX);
        delta  = s2_q - base_q;
        sum    = {1'b0, count_q} + (CNT_W + 1)'(delta);
    end

    always_comb begin
        base_d   = base_q;
        primed_d = primed_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        wrap_d   = 1'b0;
        cmp_d    = 1'b0;
        if (accept) begin
            base_d   = s2_q;
            primed_d = 1'b1;
        end
        if (clear) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (accept && primed_q && (delta != 4'd0)) begin
            count_d = sum[CNT_W-1:0];
            ovf_d   = ovf_q | sum[CNT_W];
            wrap_d  = (s2_q < base_q);
            cmp_d   = (count_q < MATCH) && (sum[CNT_W-1:0] >= MATCH);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q         <= '0;
            s2_q         <= '0;
            run_q        <= '0;
            base_q       <= '0;
            primed_q     <= 1'b0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            wrap_q       <= 1'b0;
            cmp_q        <= 1'b0;
            snap_count_q <= '0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            run_q        <= run_d;
            base_q       <= base_d;
            primed_q     <= primed_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            wrap_q       <= wrap_d;
            cmp_q        <= cmp_d;
            snap_count_q <= snap_count_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (snap_req)   state_d = HOLD;
            HOLD:    if (snap_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Snapshot takes the count as it stood before this cycle's update.
    always_comb begin
        snap_valid   = (state_q == HOLD);
        snap_count_d = snap_count_q;
        if ((state_q == IDLE) && snap_req) begin
            snap_count_d = count_q;
        end
    end

    assign snap_count = snap_count_q;
    assign count      = count_q;
    assign stable     = (run_q == RUN_MAX);
    assign wrap_pulse = wrap_q;
    assign cmp_hit    = cmp_q;
    assign overflow   = ovf_q;

endmodule
